// File: rtl/displays_seq_master.sv
// displays_seq_master: Avalon-MM initiator that steps a display pattern every
// TICK_DIV clocks, writes it to PIO offset 0, reads it back and flags any
// readback mismatch in a sticky error bit.
module displays_seq_master #(
    parameter int DATA_WIDTH = 6,
    parameter int TICK_DIV   = 50000000,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] pattern_seed,
    input  logic                  clr_err,
    output logic [1:0]            avm_address,
    output logic                  avm_chipselect,
    output logic                  avm_write_n,
    output logic [31:0]           avm_writedata,
    input  logic [31:0]           avm_readdata,
    input  logic                  avm_waitrequest,
    output logic                  busy,
    output logic                  verify_err,
    output logic [CNT_WIDTH-1:0]  write_count
);

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_CHECK = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
    logic [DATA_WIDTH-1:0]  pattern_q, pattern_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   pend_q, pend_d;
    logic                   loaded_q, loaded_d;
    logic                   err_q, err_d;
    logic [CNT_WIDTH-1:0]   wcount_q, wcount_d;

    logic                   tick;
    logic [DATA_WIDTH-1:0]  launch_pat;

    // Only the pattern bits of the readback are compared; the rest is ignored.
    logic unused_readdata;
    assign unused_readdata = ^avm_readdata[31:DATA_WIDTH];

    // Next display pattern for the selected animation mode.
    function automatic logic [DATA_WIDTH-1:0] advance(input logic [1:0] m,
                                                      input logic [DATA_WIDTH-1:0] p);
        logic [DATA_WIDTH-1:0] r;
        case (m)
            2'b01:   r = (p == '0) ? DATA_WIDTH'(1) : {p[DATA_WIDTH-2:0], p[DATA_WIDTH-1]};
            2'b10:   r = p + DATA_WIDTH'(1);
            2'b11:   r = ~p;
            default: r = p;
        endcase
        return r;
    endfunction

    assign tick       = enable && (tick_cnt_q == TICK_LAST);
    // The first write after enable rises uses the seed directly, so a reset
    // released with enable already high still starts from pattern_seed.
    assign launch_pat = loaded_q ? pattern_q : pattern_seed;

    // Next-state logic for the transfer FSM, tick divider and datapath.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        pattern_d  = pattern_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        pend_d     = pend_q;
        loaded_d   = loaded_q;
        err_d      = err_q;
        wcount_d   = wcount_q;

        if (!enable || tick) tick_cnt_d = '0;
        else                 tick_cnt_d = tick_cnt_q + TW'(1);

        if (tick && state_q != S_IDLE) pend_d = 1'b1;
        if (clr_err) err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable && (tick || pend_q)) begin
                    state_d   = S_WRITE;
                    pend_d    = 1'b0;
                    wdata_d   = launch_pat;
                    pattern_d = launch_pat;
                    loaded_d  = 1'b1;
                end
            end
            S_WRITE: begin
                if (!avm_waitrequest) begin
                    wcount_d = wcount_q + CNT_WIDTH'(1);
                    state_d  = S_READ;
                end
            end
            S_READ: begin
                if (!avm_waitrequest) begin
                    rdata_d = avm_readdata[DATA_WIDTH-1:0];
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                // A mismatch overrides a simultaneous clr_err.
                if (rdata_q != wdata_q) err_d = 1'b1;
                pattern_d = advance(mode, wdata_q);
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Disabled: keep reloading the seed and forget any queued tick.
        if (!enable) begin
            pattern_d = pattern_seed;
            pend_d    = 1'b0;
            loaded_d  = 1'b0;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            pattern_q  <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            pend_q     <= 1'b0;
            loaded_q   <= 1'b0;
            err_q      <= 1'b0;
            wcount_q   <= '0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            pattern_q  <= pattern_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            pend_q     <= pend_d;
            loaded_q   <= loaded_d;
            err_q      <= err_d;
            wcount_q   <= wcount_d;
        end
    end

    assign avm_address    = 2'b00;
    assign avm_chipselect = (state_q == S_WRITE) || (state_q == S_READ);
    assign avm_write_n    = (state_q != S_WRITE);
    assign avm_writedata  = {{(32-DATA_WIDTH){1'b0}}, wdata_q};
    assign busy           = (state_q != S_IDLE);
    assign verify_err     = err_q;
    assign write_count    = wcount_q;

endmodule

// File: tb/tb_displays_seq_master.sv
// Directed bench for displays_seq_master with TICK_DIV=4 and a 3-bit write
// counter, against a PIO register slave model that echoes writes on read.
module tb_displays_seq_master;

    localparam int DW = 6;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [DW-1:0] pattern_seed = '0;
    logic          clr_err = 1'b0;
    logic [1:0]    avm_address;
    logic          avm_chipselect;
    logic          avm_write_n;
    logic [31:0]   avm_writedata;
    logic [31:0]   avm_readdata;
    logic          avm_waitrequest = 1'b0;
    logic          busy;
    logic          verify_err;
    logic [CW-1:0] write_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [DW-1:0] pio_q = '0;
    logic          flip = 1'b0;
    logic [31:0]   wr_data[$];
    int            wr_cyc[$];

    displays_seq_master #(.DATA_WIDTH(DW), .TICK_DIV(4), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .pattern_seed(pattern_seed), .clr_err(clr_err),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
        .busy(busy), .verify_err(verify_err), .write_count(write_count)
    );

    always #5 clk = ~clk;

    // PIO slave model; optional bit0 corruption on readback.
    assign avm_readdata = {26'b0, pio_q ^ {5'b0, flip}};

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (avm_chipselect && !avm_write_n && !avm_waitrequest) begin
            pio_q <= avm_writedata[DW-1:0];
            wr_data.push_back(avm_writedata);
            wr_cyc.push_back(cyc);
            $display("  write #%0d data=%h cycle=%0d", wr_data.size(), avm_writedata, cyc);
        end
    end

    task automatic wait_writes(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (wr_data.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if (avm_chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs got=%b exp=0", avm_chipselect); end
        checks++; if (avm_write_n !== 1'b1) begin errors++; $display("FAIL reset_wn got=%b exp=1", avm_write_n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (verify_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", verify_err); end
        checks++; if (write_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", write_count); end
        checks++; if (avm_writedata !== 32'h0 || avm_address !== 2'b00) begin errors++; $display("FAIL reset_bus got=%h/%b exp=0/0", avm_writedata, avm_address); end
        reset = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_disabled busy=%b exp=0", busy); end
        $display("test_reset done");
    endtask

    task automatic test_walking_one;
        logic [31:0] exp_w[7] = '{32'h01, 32'h02, 32'h04, 32'h08, 32'h10, 32'h20, 32'h01};
        bit ok;
        mode = 2'b01; pattern_seed = 6'h01;
        @(negedge clk);
        wr_data.delete(); wr_cyc.delete();
        enable = 1'b1;
        wait_writes(7, 80, ok);
        enable = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL walk_timeout writes=%0d exp=7", wr_data.size()); end
        checks++; if (wr_data.size() != 7) begin errors++; $display("FAIL walk_nwrites got=%0d exp=7", wr_data.size()); end
        for (int i = 0; i < 7 && i < wr_data.size(); i++) begin
            checks++;
            if (wr_data[i] !== exp_w[i]) begin errors++; $display("FAIL walk_data[%0d] got=%h exp=%h", i, wr_data[i], exp_w[i]); end
        end
        for (int i = 1; i < 7 && i < wr_cyc.size(); i++) begin
            checks++;
            if (wr_cyc[i] - wr_cyc[i-1] != 4) begin errors++; $display("FAIL walk_period[%0d] got=%0d exp=4", i, wr_cyc[i] - wr_cyc[i-1]); end
        end
        wait_idle(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL walk_idle_timeout busy=%b exp=0", busy); end
        checks++; if (verify_err !== 1'b0) begin errors++; $display("FAIL walk_err got=%b exp=0", verify_err); end
        checks++; if (write_count !== 3'd7) begin errors++; $display("FAIL walk_count got=%0d exp=7", write_count); end
        $display("test_walking_one done");
    endtask

    task automatic test_stall;
        bit ok;
        mode = 2'b00; pattern_seed = 6'h2A;
        wr_data.delete(); wr_cyc.delete();
        avm_waitrequest = 1'b1;
        enable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (avm_chipselect && !avm_write_n) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL stall_no_write cs=%b wn=%b exp=1/0", avm_chipselect, avm_write_n); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (avm_writedata !== 32'h2A || avm_address !== 2'b00 || avm_write_n !== 1'b0 || avm_chipselect !== 1'b1)
                begin errors++; $display("FAIL stall_hold[%0d] got=%h/%b/%b/%b exp=0000002a/00/0/1", i, avm_writedata, avm_address, avm_write_n, avm_chipselect); end
            checks++;
            if (write_count !== 3'd7) begin errors++; $display("FAIL stall_count[%0d] got=%0d exp=7", i, write_count); end
            @(negedge clk);
        end
        avm_waitrequest = 1'b0;
        @(negedge clk);
        enable = 1'b0;
        checks++; if (write_count !== 3'd0) begin errors++; $display("FAIL count_wrap got=%0d exp=0", write_count); end
        wait_idle(20, ok);
        checks++; if (wr_data.size() != 1 || wr_data[0] !== 32'h2A) begin errors++; $display("FAIL stall_once n=%0d exp=1 data=2a", wr_data.size()); end
        checks++; if (write_count !== 3'd0) begin errors++; $display("FAIL stall_count_final got=%0d exp=0", write_count); end
        $display("test_stall done");
    endtask

    task automatic test_mismatch;
        bit ok;
        mode = 2'b00; pattern_seed = 6'h05;
        wr_data.delete(); wr_cyc.delete();
        flip = 1'b1; enable = 1'b1;
        wait_writes(1, 20, ok);
        enable = 1'b0;
        wait_idle(20, ok);
        checks++; if (verify_err !== 1'b1) begin errors++; $display("FAIL mis_set got=%b exp=1", verify_err); end
        flip = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (verify_err !== 1'b1) begin errors++; $display("FAIL mis_sticky got=%b exp=1", verify_err); end
        clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
        checks++; if (verify_err !== 1'b0) begin errors++; $display("FAIL mis_clear got=%b exp=0", verify_err); end
        flip = 1'b1; enable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy && !avm_chipselect) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL mis_no_check busy=%b cs=%b exp=1/0", busy, avm_chipselect); end
        clr_err = 1'b1; @(negedge clk); clr_err = 1'b0; enable = 1'b0;
        checks++; if (verify_err !== 1'b1) begin errors++; $display("FAIL mis_set_wins got=%b exp=1", verify_err); end
        flip = 1'b0;
        wait_idle(20, ok);
        clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
        checks++; if (verify_err !== 1'b0) begin errors++; $display("FAIL mis_clear2 got=%b exp=0", verify_err); end
        $display("test_mismatch done");
    endtask

    task automatic test_increment_invert;
        logic [31:0] exp_inv[3] = '{32'h15, 32'h2A, 32'h15};
        bit ok;
        mode = 2'b10; pattern_seed = 6'h3F;
        wr_data.delete(); wr_cyc.delete();
        enable = 1'b1;
        wait_writes(2, 30, ok);
        enable = 1'b0;
        wait_idle(20, ok);
        checks++; if (wr_data.size() != 2) begin errors++; $display("FAIL inc_n got=%0d exp=2", wr_data.size()); end
        if (wr_data.size() >= 2) begin
            checks++; if (wr_data[0] !== 32'h3F) begin errors++; $display("FAIL inc_w0 got=%h exp=3f", wr_data[0]); end
            checks++; if (wr_data[1] !== 32'h00) begin errors++; $display("FAIL inc_wrap got=%h exp=00", wr_data[1]); end
        end
        mode = 2'b11; pattern_seed = 6'h15;
        @(negedge clk);
        wr_data.delete(); wr_cyc.delete();
        enable = 1'b1;
        wait_writes(3, 40, ok);
        enable = 1'b0;
        wait_idle(20, ok);
        checks++; if (wr_data.size() != 3) begin errors++; $display("FAIL inv_n got=%0d exp=3", wr_data.size()); end
        for (int i = 0; i < 3 && i < wr_data.size(); i++) begin
            checks++;
            if (wr_data[i] !== exp_inv[i]) begin errors++; $display("FAIL inv_w%0d got=%h exp=%h", i, wr_data[i], exp_inv[i]); end
        end
        $display("test_increment_invert done");
    endtask

    task automatic test_reset_during_write;
        bit ok;
        int n;
        mode = 2'b00; pattern_seed = 6'h33;
        avm_waitrequest = 1'b1; enable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (avm_chipselect && !avm_write_n) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL rst_no_write cs=%b exp=1", avm_chipselect); end
        reset = 1'b1;
        #1;
        checks++; if (avm_chipselect !== 1'b0) begin errors++; $display("FAIL rst_cs got=%b exp=0", avm_chipselect); end
        checks++; if (avm_write_n !== 1'b1) begin errors++; $display("FAIL rst_wn got=%b exp=1", avm_write_n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (write_count !== 3'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", write_count); end
        checks++; if (verify_err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", verify_err); end
        pattern_seed = 6'h0C; avm_waitrequest = 1'b0;
        wr_data.delete(); wr_cyc.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (avm_chipselect) break;
        end
        checks++; if (n != 4) begin errors++; $display("FAIL rst_latency got=%0d exp=4", n); end
        wait_writes(1, 10, ok);
        enable = 1'b0;
        checks++; if (!ok || wr_data[0] !== 32'h0C) begin errors++; $display("FAIL rst_seed n=%0d exp=1 data=0c", wr_data.size()); end
        wait_idle(20, ok);
        checks++; if (write_count !== 3'd1) begin errors++; $display("FAIL rst_count_after got=%0d exp=1", write_count); end
        $display("test_reset_during_write done");
    endtask

    initial begin
        test_reset();
        test_walking_one();
        test_stall();
        test_mismatch();
        test_increment_invert();
        test_reset_during_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
